sbox_lanes: RTL and testbench

//  LANES-wide pipelined AES S-box bank with per-beat forward/inverse mode and valid/ready flow control.

---
 rtl/sbox_lanes.sv | 254 +++++++++++++++++++++++++
 tb/tb_sbox_lanes.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_lanes.sv
`default_nettype none
// ============================================================================
// Module   : sbox_lanes
// Purpose  : LANES-wide pipelined AES S-box bank. The byte inverse is built on
//            the GF((2^4)^2) composite field. Per-beat forward/inverse mode,
//            opaque tag sideband, valid/ready handshakes, fixed 5-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_lanes #(
  parameter int LANES  = 4,
  parameter int TAG_W  = 4,
  parameter int INV_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_mode
);

  // --------------------------------------------------------------------------
  // GF(2^4) arithmetic, polynomial basis modulo x^4 + x + 1
  // --------------------------------------------------------------------------
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // a^14 is the multiplicative inverse for a != 0 and yields 0 for a == 0
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_mul(a, a);
    a4 = gf4_mul(a2, a2);
    a8 = gf4_mul(a4, a4);
    return gf4_mul(gf4_mul(a2, a4), a8);
  endfunction

  // --------------------------------------------------------------------------
  // Elaboration-time derivation of the composite field and its basis change.
  // Deriving the constants (rather than hard-coding matrices) keeps the
  // iso/inverse-iso pair consistent with the chosen lambda by construction.
  // --------------------------------------------------------------------------

  // Smallest lambda for which y^2 + y + lambda has no root in GF(2^4)
  function automatic logic [3:0] find_lambda();
    logic [3:0] lam;
    logic       found;
    logic       ok;
    lam   = 4'h0;
    found = 1'b0;
    for (int l = 1; l < 16; l++) begin
      ok = 1'b1;
      for (int t = 0; t < 16; t++) begin
        if ((gf4_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(l)) ok = 1'b0;
      end
      if (ok && !found) begin
        lam   = 4'(l);
        found = 1'b1;
      end
    end
    return lam;
  endfunction

  // Composite multiply: element = hi*Y + lo with Y^2 = Y + lambda
  function automatic logic [7:0] gf8c_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] lam);
    logic [3:0] hh;
    logic [3:0] hi;
    logic [3:0] lo;
    hh = gf4_mul(a[7:4], b[7:4]);
    hi = hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]);
    lo = gf4_mul(a[3:0], b[3:0]) ^ gf4_mul(lam, hh);
    return {hi, lo};
  endfunction

  // Columns of the iso map: column i = beta^i, beta a root of the AES polynomial
  function automatic logic [63:0] iso_cols(input logic [3:0] lam);
    logic [7:0]  beta, b, b2, b3, b4, b8, p;
    logic        found;
    logic [63:0] cols;
    beta  = 8'h00;
    found = 1'b0;
    for (int c = 2; c < 256; c++) begin
      b  = 8'(c);
      b2 = gf8c_mul(b, b, lam);
      b3 = gf8c_mul(b2, b, lam);
      b4 = gf8c_mul(b2, b2, lam);
      b8 = gf8c_mul(b4, b4, lam);
      if (!found && ((b8 ^ b4 ^ b3 ^ b ^ 8'h01) == 8'h00)) begin
        beta  = b;
        found = 1'b1;
      end
    end
    cols = 64'h0;
    p    = 8'h01;
    for (int i = 0; i < 8; i++) begin
      cols[8*i +: 8] = p;
      p = gf8c_mul(p, beta, lam);
    end
    return cols;
  endfunction

  // GF(2)-linear byte map given its eight columns
  function automatic logic [7:0] lin_map(input logic [63:0] cols, input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) r = r ^ cols[8*i +: 8];
    end
    return r;
  endfunction

  // Inverse of a bijective linear map: find the preimage of each unit vector
  function automatic logic [63:0] inv_cols(input logic [63:0] cols);
    logic [63:0] res;
    logic [7:0]  y;
    res = 64'h0;
    for (int c = 0; c < 256; c++) begin
      y = lin_map(cols, 8'(c));
      for (int j = 0; j < 8; j++) begin
        if (y == 8'(1 << j)) res[8*j +: 8] = 8'(c);
      end
    end
    return res;
  endfunction

  // AES affine transform including the 0x63 constant
  function automatic logic [7:0] aff_fwd(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // Linear part of the inverse affine transform
  function automatic logic [7:0] aff_inv_lin(input logic [7:0] y);
    return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]};
  endfunction

  localparam logic [3:0]  LAMBDA  = find_lambda();
  localparam logic [63:0] ISO     = iso_cols(LAMBDA);
  localparam logic [63:0] ISO_INV = inv_cols(ISO);

  // --------------------------------------------------------------------------
  // Pipeline state: per-stage valid/mode/tag plus per-lane datapath registers
  // --------------------------------------------------------------------------
  logic [4:0]            vld;
  logic [4:0]            md;
  logic [4:0][TAG_W-1:0] tg;

  logic [LANES-1:0][3:0] s0_hi, s0_lo, s0_hl;
  logic [LANES-1:0][3:0] s1_d,  s1_hi, s1_hl;
  logic [LANES-1:0][3:0] s2_di, s2_hi, s2_hl;
  logic [LANES-1:0][7:0] s3_z;
  logic [8*LANES-1:0]    s4_q;

  logic [LANES-1:0][3:0] n0_hi, n0_lo, n0_hl;
  logic [LANES-1:0][3:0] n1_d;
  logic [LANES-1:0][3:0] n2_di;
  logic [LANES-1:0][7:0] n3_z;
  logic [8*LANES-1:0]    n4_q;

  logic adv;
  logic mode_in;

  // Whole pipe moves together; bubbles are held rather than collapsed
  assign adv       = !vld[4] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[4];
  assign out_mode  = md[4];
  assign out_tag   = tg[4];
  assign out_data  = s4_q;

  if (INV_EN != 0) begin : g_inv
    assign mode_in = in_mode;
  end else begin : g_fwd_only
    // Mode tied low so the inverse-side muxing folds away
    assign mode_in = 1'b0;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] pre;
    logic [7:0] m;
    logic [7:0] w;

    // S0: optional inverse affine, then change to composite basis and split
    assign pre      = mode_in ? aff_inv_lin(in_data[8*i +: 8] ^ 8'h63) : in_data[8*i +: 8];
    assign m        = lin_map(ISO, pre);
    assign n0_hi[i] = m[7:4];
    assign n0_lo[i] = m[3:0];
    assign n0_hl[i] = m[7:4] ^ m[3:0];

    // S1: norm of the composite element
    assign n1_d[i]  = gf4_mul(LAMBDA, gf4_mul(s0_hi[i], s0_hi[i])) ^ gf4_mul(s0_hl[i], s0_lo[i]);

    // S2: subfield inverse of the norm
    assign n2_di[i] = gf4_inv(s1_d[i]);

    // S3: assemble composite inverse
    assign n3_z[i]  = {gf4_mul(s2_hi[i], s2_di[i]), gf4_mul(s2_hl[i], s2_di[i])};

    // S4: back to polynomial basis, forward beats get the affine transform
    assign w                 = lin_map(ISO_INV, s3_z[i]);
    assign n4_q[8*i +: 8]    = md[3] ? w : aff_fwd(w);
  end

  // Stage registers: clear on reset, shift one stage whenever the pipe advances
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld   <= '0;
      md    <= '0;
      tg    <= '0;
      s0_hi <= '0;
      s0_lo <= '0;
      s0_hl <= '0;
      s1_d  <= '0;
      s1_hi <= '0;
      s1_hl <= '0;
      s2_di <= '0;
      s2_hi <= '0;
      s2_hl <= '0;
      s3_z  <= '0;
      s4_q  <= '0;
    end else if (adv) begin
      vld   <= {vld[3:0], in_valid};
      md    <= {md[3:0], mode_in};
      tg    <= {tg[3:0], in_tag};
      s0_hi <= n0_hi;
      s0_lo <= n0_lo;
      s0_hl <= n0_hl;
      s1_d  <= n1_d;
      s1_hi <= s0_hi;
      s1_hl <= s0_hl;
      s2_di <= n2_di;
      s2_hi <= s1_hi;
      s2_hl <= s1_hl;
      s3_z  <= n3_z;
      s4_q  <= n4_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sbox_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_lanes
// Purpose  : Self-checking bench for sbox_lanes against a table model of the
//            AES S-box built from GF(2^8) arithmetic modulo 0x11B.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_lanes;

  localparam int LANES = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        mode;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_mode;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready, out_mode;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  logic        f_in_valid, f_in_ready, f_in_mode;
  logic [31:0] f_in_data;
  logic [3:0]  f_in_tag;
  logic        f_out_valid, f_out_ready, f_out_mode;
  logic [31:0] f_out_data;
  logic [3:0]  f_out_tag;

  sbox_lanes #(.LANES(LANES), .TAG_W(TAG_W), .INV_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_mode(out_mode)
  );

  sbox_lanes #(.LANES(LANES), .TAG_W(TAG_W), .INV_EN(0)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_mode(f_in_mode),
    .in_data(f_in_data), .in_tag(f_in_tag),
    .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_data(f_out_data), .out_tag(f_out_tag), .out_mode(f_out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  sbox  [256];
  logic [7:0]  isbox [256];
  beat_t       exp_q [$];
  logic        hold;
  beat_t       hold_beat;
  logic        popped;
  beat_t       last;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_sub(input logic [31:0] d, input logic m);
    logic [31:0] r;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = m ? isbox[d[8*i +: 8]] : sbox[d[8*i +: 8]];
    return r;
  endfunction

  // One clock of stimulus plus output checking against the scoreboard
  task automatic step(input logic v, input logic m, input logic [31:0] d,
                      input logic [3:0] t, input logic ordy);
    beat_t b;
    @(negedge clk);
    in_valid  = v;
    in_mode   = m;
    in_data   = d;
    in_tag    = t;
    out_ready = ordy;
    #1;
    if (hold) begin
      check("stall_valid", 64'(out_valid), 64'(1'b1));
      check("stall_data",  64'(out_data),  64'(hold_beat.data));
      check("stall_tag",   64'(out_tag),   64'(hold_beat.tag));
      check("stall_mode",  64'(out_mode),  64'(hold_beat.mode));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 64'(out_valid), 64'(1'b0));
      end else begin
        b = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(b.data));
        check("out_tag",  64'(out_tag),  64'(b.tag));
        check("out_mode", 64'(out_mode), 64'(b.mode));
        last.data = out_data;
        last.tag  = out_tag;
        last.mode = out_mode;
        popped = 1'b1;
      end
    end
    hold           = out_valid && !out_ready;
    hold_beat.data = out_data;
    hold_beat.tag  = out_tag;
    hold_beat.mode = out_mode;
    if (v && in_ready) begin
      b.data = ref_sub(d, m);
      b.tag  = t;
      b.mode = m;
      exp_q.push_back(b);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  inv;
    logic [7:0]  s;
    logic [7:0]  c;
    logic [31:0] d;
    int          lat;
    logic        found;

    rst_n = 1'b0;
    in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    f_in_valid = 1'b0; f_in_mode = 1'b0; f_in_data = '0; f_in_tag = '0; f_out_ready = 1'b1;
    hold = 1'b0; popped = 1'b0; last = '0;

    // Reference tables: multiplicative inverse by search, then textbook affine
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data",  64'(out_data),  64'(0));
    check("rst_out_tag",   64'(out_tag),   64'(0));
    check("rst_out_mode",  64'(out_mode),  64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_f_valid",   64'(f_out_valid), 64'(0));
    rst_n = 1'b1;

    // Known forward vector and latency
    step(1'b1, 1'b0, 32'h530100FF, 4'h3, 1'b1);
    lat = 0; popped = 1'b0;
    while (!popped && lat < 20) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
      lat++;
    end
    check("latency_fwd", 64'(lat), 64'(5));
    check("fwd_vector",  64'(last.data), 64'(32'hED7C6316));

    // Known inverse vector with tag and mode returned
    step(1'b1, 1'b1, 32'hED7C6316, 4'hA, 1'b1);
    lat = 0; popped = 1'b0;
    while (!popped && lat < 20) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
      lat++;
    end
    check("latency_inv", 64'(lat), 64'(5));
    check("inv_vector",  64'(last.data), 64'(32'h530100FF));
    check("inv_tag",     64'(last.tag),  64'(4'hA));
    check("inv_mode",    64'(last.mode), 64'(1'b1));

    // Every byte value in every lane, alternating forward and inverse beats
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < LANES; i++) d[8*i +: 8] = 8'(k + 67*i);
      step(1'b1, 1'b0, d, 4'(k), 1'b1);
      step(1'b1, 1'b1, d, 4'(k + 1), 1'b1);
    end
    drain();

    // Random traffic with random backpressure and gappy input
    for (int k = 0; k < 300; k++)
      step(1'(($urandom % 4) != 0), 1'($urandom % 2), $urandom, 4'($urandom),
           1'($urandom % 2));
    drain();

    // Reset with three beats in flight
    for (int k = 0; k < 3; k++) step(1'b1, 1'(k % 2), $urandom, 4'(k + 7), 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    hold = 1'b0;
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_data",  64'(out_data),  64'(0));
    check("midrst_ready", 64'(in_ready),  64'(1));
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);

    // Forward-only instance ignores in_mode
    @(negedge clk);
    f_in_valid = 1'b1; f_in_mode = 1'b1; f_in_data = 32'h00530100; f_in_tag = 4'h5;
    #1;
    check("f_in_ready", 64'(f_in_ready), 64'(1));
    @(negedge clk);
    f_in_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!found && f_out_valid) begin
        found = 1'b1;
        check("f_data", 64'(f_out_data), 64'(32'h63ED7C63));
        check("f_mode", 64'(f_out_mode), 64'(0));
        check("f_tag",  64'(f_out_tag),  64'(4'h5));
      end
      @(negedge clk);
    end
    check("f_seen", 64'(found), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
